// File: rtl/fp_seq_adder.sv
// Sequential floating-point adder: fetches operands from a synchronous ROM, adds them
// with a truncating IEEE-style datapath and keeps the results in a readback buffer.
module fp_seq_adder #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int ROM_AW = 3,
  parameter int RES_AW = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   mode,
  input  logic [RES_AW:0]        n_ops,
  output logic                   rom_rd,
  output logic [ROM_AW-1:0]      rom_addr,
  input  logic [EXP_W+MAN_W:0]   rom_data,
  input  logic [RES_AW-1:0]      rd_addr,
  output logic [EXP_W+MAN_W:0]   rd_data,
  output logic                   busy,
  output logic                   done,
  output logic                   ovf
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int MW  = MAN_W + 1;
  localparam int LZW = $clog2(MAN_W + 2);
  localparam int EXW = EXP_W + 2;
  localparam int D   = 2 ** RES_AW;
  localparam logic [RES_AW:0]  D_CNT   = (RES_AW+1)'(D);
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_A, S_FETCH_B, S_ALIGN, S_ADD, S_NORM, S_WRITE, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ROM_AW-1:0] ptr_q, ptr_d;
  logic [RES_AW:0]   k_q, k_d;
  logic [RES_AW:0]   nops_q, nops_d;
  logic              mode_q, mode_d;
  logic              ovf_q, ovf_d;
  logic              acc_skip;

  logic [W-1:0]      a_q;
  logic [W-1:0]      acc_q;
  logic [W-1:0]      res_q;
  logic              res_ovf_q;
  logic              sign_q;
  logic              sub_q;
  logic [EXP_W-1:0]  exp_q;
  logic [MW-1:0]     mant_l_q;
  logic [MW-1:0]     mant_s_q;
  logic [MW:0]       sum_q;
  logic [W-1:0]      buf_q [D];

  function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] v);
    logic [LZW-1:0] n;
    logic           found;
    n     = '0;
    found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n     = n + 1'b1;
      end
    end
    return n;
  endfunction

  // Packs a normalised result, flushing underflow to +0 and saturating to signed inf.
  // Returns {saturated, word}.
  function automatic logic [W:0] pack_sat(input logic sign, input logic [EXW-1:0] e,
                                          input logic [MAN_W-1:0] m);
    if (e[EXW-1] || (e == '0))
      return '0;
    else if (e[EXW-2:0] >= {1'b0, EXP_MAX})
      return {1'b1, sign, EXP_MAX, {MAN_W{1'b0}}};
    else
      return {1'b0, sign, e[EXP_W-1:0], m};
  endfunction

  assign acc_skip = mode_q && (k_q != '0);

  // Alignment: a_q holds the first operand, rom_data the second.
  logic             sa, sb, sign_l, a_big;
  logic [EXP_W-1:0] ea, eb, e_l, e_s, e_diff;
  logic [MW-1:0]    ma, mb, m_l, m_s, m_s_sh;

  always_comb begin
    sa     = a_q[W-1];
    sb     = rom_data[W-1];
    ea     = a_q[W-2 -: EXP_W];
    eb     = rom_data[W-2 -: EXP_W];
    ma     = (ea == '0) ? '0 : {1'b1, a_q[MAN_W-1:0]};
    mb     = (eb == '0) ? '0 : {1'b1, rom_data[MAN_W-1:0]};
    a_big  = {ea, ma} >= {eb, mb};
    e_l    = a_big ? ea : eb;
    e_s    = a_big ? eb : ea;
    m_l    = a_big ? ma : mb;
    m_s    = a_big ? mb : ma;
    sign_l = a_big ? sa : sb;
    e_diff = e_l - e_s;
    m_s_sh = (e_diff >= EXP_W'(MAN_W + 2)) ? '0 : (m_s >> e_diff);
  end

  // Normalisation of the registered mantissa sum.
  logic [LZW-1:0] nz;
  logic [MW-1:0]  m_norm;
  logic [EXW-1:0] e_norm;
  logic [W:0]     packed_r;

  always_comb begin
    nz = lzc(sum_q[MW-1:0]);
    if (sum_q[MW]) begin
      m_norm = sum_q[MW:1];
      e_norm = {2'b00, exp_q} + EXW'(1);
    end else begin
      m_norm = sum_q[MW-1:0] << nz;
      e_norm = {2'b00, exp_q} - EXW'(nz);
    end
    if (sum_q == '0) packed_r = '0;
    else             packed_r = pack_sat(sign_q, e_norm, m_norm[MAN_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    k_d     = k_q;
    nops_d  = nops_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          ptr_d   = '0;
          k_d     = '0;
          ovf_d   = 1'b0;
          mode_d  = mode;
          nops_d  = (n_ops > D_CNT) ? D_CNT : n_ops;
          state_d = S_FETCH_A;
        end
      end
      S_FETCH_A: state_d = (nops_q == '0) ? S_DONE : S_FETCH_B;
      S_FETCH_B: state_d = S_ALIGN;
      S_ALIGN:   state_d = S_ADD;
      S_ADD:     state_d = S_NORM;
      S_NORM:    state_d = S_WRITE;
      S_WRITE: begin
        k_d   = k_q + 1'b1;
        ptr_d = ptr_q + (mode_q ? ROM_AW'(1) : ROM_AW'(2));
        ovf_d = ovf_q | res_ovf_q;
        if (k_d == nops_q) state_d = S_DONE;
        else if (mode_q)   state_d = S_FETCH_B;
        else               state_d = S_FETCH_A;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rom_rd   = 1'b0;
    rom_addr = '0;
    busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    done     = (state_q == S_DONE);
    if (state_q == S_FETCH_A) begin
      rom_rd   = 1'b1;
      rom_addr = ptr_q;
    end else if (state_q == S_FETCH_B) begin
      rom_rd   = 1'b1;
      rom_addr = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      k_q    <= '0;
      nops_q <= '0;
      mode_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      k_q    <= k_d;
      nops_q <= nops_d;
      mode_q <= mode_d;
      ovf_q  <= ovf_d;
    end
  end

  // Datapath registers; the buffer write is gated so a reset edge never commits a result.
  always_ff @(posedge clk) begin
    if (state_q == S_FETCH_B) a_q <= acc_skip ? acc_q : rom_data;
    if (state_q == S_ALIGN) begin
      sign_q   <= sign_l;
      sub_q    <= sa ^ sb;
      exp_q    <= e_l;
      mant_l_q <= m_l;
      mant_s_q <= m_s_sh;
    end
    if (state_q == S_ADD)
      sum_q <= sub_q ? ({1'b0, mant_l_q} - {1'b0, mant_s_q})
                     : ({1'b0, mant_l_q} + {1'b0, mant_s_q});
    if (state_q == S_NORM) begin
      res_q     <= packed_r[W-1:0];
      res_ovf_q <= packed_r[W];
    end
    if ((state_q == S_WRITE) && rst_n) begin
      buf_q[k_q[RES_AW-1:0]] <= res_q;
      acc_q                  <= res_q;
    end
  end

  assign rd_data = done ? buf_q[rd_addr] : '0;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_fp_seq_adder.sv
// Directed bench for fp_seq_adder: PAIR/ACC sums, cancellation, large shifts,
// overflow, op-count edge cases, ignored start and mid-run reset.
module tb_fp_seq_adder;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int ROM_AW = 3;
  localparam int RES_AW = 2;
  localparam int W      = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic [RES_AW:0]   n_ops = '0;
  logic              rom_rd;
  logic [ROM_AW-1:0] rom_addr;
  logic [W-1:0]      rom_data;
  logic [RES_AW-1:0] rd_addr = '0;
  logic [W-1:0]      rd_data;
  logic              busy, done, ovf;
  logic [W-1:0]      rom [8];

  int n_checks = 0;
  int n_fail   = 0;

  fp_seq_adder #(
    .EXP_W(EXP_W), .MAN_W(MAN_W), .ROM_AW(ROM_AW), .RES_AW(RES_AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .n_ops(n_ops),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_rd) rom_data <= rom[rom_addr];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_rom(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                         input logic [31:0] w3, input logic [31:0] w4, input logic [31:0] w5,
                         input logic [31:0] w6, input logic [31:0] w7);
    rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
    rom[4] = w4; rom[5] = w5; rom[6] = w6; rom[7] = w7;
  endtask

  task automatic kick(input logic m, input logic [RES_AW:0] n);
    @(negedge clk);
    mode  = m;
    n_ops = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the number of edges from the start-accept edge until done is seen.
  task automatic run(input logic m, input logic [RES_AW:0] n, input int poke_at, output int cyc);
    kick(m, n);
    cyc = 0;
    while (!done && cyc < 100) begin
      if (cyc == poke_at) begin
        start = 1'b1;
        mode  = ~m;
        n_ops = 3'd1;
      end
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end
  endtask

  task automatic check_res(input string tag, input int idx, input logic [31:0] exp);
    rd_addr = idx[RES_AW-1:0];
    #1;
    check_val(tag, rd_data, exp);
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    check_val("rst_busy",  32'(busy),     32'd0);
    check_val("rst_done",  32'(done),     32'd0);
    check_val("rst_ovf",   32'(ovf),      32'd0);
    check_val("rst_romrd", 32'(rom_rd),   32'd0);
    check_val("rst_addr",  32'(rom_addr), 32'd0);
    check_val("rst_rd",    rd_data,       32'd0);
    rst_n = 1'b1;

    // PAIR, three sums
    set_rom(32'h3F800000, 32'h3E800000, 32'h40400000, 32'h41200000,
            32'h3EA00000, 32'h3F600000, 32'h0, 32'h0);
    run(1'b0, 3'd3, -1, cyc);
    check_val("t1_lat", cyc, 32'd18);
    check_val("t1_busy", 32'(busy), 32'd0);
    check_val("t1_ovf", 32'(ovf), 32'd0);
    check_res("t1_r0", 0, 32'h3FA00000);
    check_res("t1_r1", 1, 32'h41500000);
    check_res("t1_r2", 2, 32'h3F980000);

    // ACC, running sum
    set_rom(32'h3F800000, 32'h3E800000, 32'h40400000, 32'h41200000,
            32'h0, 32'h0, 32'h0, 32'h0);
    run(1'b1, 3'd3, -1, cyc);
    check_val("t2_lat", cyc, 32'd16);
    check_res("t2_r0", 0, 32'h3FA00000);
    check_res("t2_r1", 1, 32'h40880000);
    check_res("t2_r2", 2, 32'h41640000);

    // cancellation to +0, then an operand shifted out entirely
    set_rom(32'h40400000, 32'hC0400000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    run(1'b0, 3'd1, -1, cyc);
    check_val("t3_lat", cyc, 32'd6);
    check_res("t3_cancel", 0, 32'h00000000);
    set_rom(32'h3F800000, 32'h33000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    run(1'b0, 3'd1, -1, cyc);
    check_res("t3_shift25", 0, 32'h3F800000);

    // overflow to inf, then ovf cleared by the next run
    set_rom(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    run(1'b0, 3'd1, -1, cyc);
    check_res("t4_inf", 0, 32'h7F800000);
    check_val("t4_ovf", 32'(ovf), 32'd1);
    set_rom(32'h3F800000, 32'h3E800000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    run(1'b0, 3'd1, -1, cyc);
    check_val("t4_ovf_clr", 32'(ovf), 32'd0);
    check_res("t4_r0", 0, 32'h3FA00000);

    // zero ops: one cycle, buffer untouched
    run(1'b0, 3'd0, -1, cyc);
    check_val("t5_zero_lat", cyc, 32'd1);
    check_val("t5_zero_done", 32'(done), 32'd1);
    check_res("t5_zero_keep", 0, 32'h3FA00000);

    // op count above depth clamps to four results
    set_rom(32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40000000,
            32'h40400000, 32'h3F000000, 32'h41200000, 32'h3F800000);
    run(1'b0, 3'd7, -1, cyc);
    check_val("t5_clamp_lat", cyc, 32'd24);
    check_res("t5_clamp_r0", 0, 32'h40000000);
    check_res("t5_clamp_r1", 1, 32'h40800000);
    check_res("t5_clamp_r2", 2, 32'h40600000);
    check_res("t5_clamp_r3", 3, 32'h41300000);

    // start pulsed mid-run is ignored
    set_rom(32'h3F800000, 32'h3E800000, 32'h40400000, 32'h41200000,
            32'h3EA00000, 32'h3F600000, 32'h0, 32'h0);
    run(1'b0, 3'd3, 3, cyc);
    check_val("t5_busy_lat", cyc, 32'd18);
    check_res("t5_busy_r1", 1, 32'h41500000);
    check_res("t5_busy_r2", 2, 32'h3F980000);

    // reset during ALIGN of op 1, after op 0 saturated
    set_rom(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h3F800000, 32'h3E800000,
            32'h40400000, 32'h41200000, 32'h0, 32'h0);
    kick(1'b0, 3'd3);
    repeat (8) @(negedge clk);
    check_val("t6_pre_busy", 32'(busy), 32'd1);
    check_val("t6_pre_ovf", 32'(ovf), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_val("t6_busy", 32'(busy), 32'd0);
    check_val("t6_done", 32'(done), 32'd0);
    check_val("t6_ovf", 32'(ovf), 32'd0);
    check_val("t6_romrd", 32'(rom_rd), 32'd0);
    check_res("t6_rd", 0, 32'h00000000);
    set_rom(32'h3F800000, 32'h3E800000, 32'h40400000, 32'h41200000,
            32'h3EA00000, 32'h3F600000, 32'h0, 32'h0);
    run(1'b0, 3'd3, -1, cyc);
    check_val("t6_lat", cyc, 32'd18);
    check_res("t6_r0", 0, 32'h3FA00000);
    check_res("t6_r1", 1, 32'h41500000);
    check_res("t6_r2", 2, 32'h3F980000);
    check_val("t6_ovf_after", 32'(ovf), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
